// File: rtl/sys_mac_pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sys_mac_pe_pkg
//  Description : Shared constants and types for the systolic MAC processing
//                element. It holds the default widths, the multiplier latency
//                limits, the arithmetic-mode encoding and the beat tag type.
//  Revision    : 1.0  initial release
// ============================================================================
package sys_mac_pe_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ACC_W   = 72;
   localparam int DEF_MUL_LAT = 3;

   localparam int MUL_LAT_MIN = 1;
   localparam int MUL_LAT_MAX = 8;

   // Encoding of the SIGNED parameter.
   localparam int ARITH_UNSIGNED = 0;
   localparam int ARITH_SIGNED   = 1;

   // Dot-product framing carried alongside each product.
   typedef struct packed {
      logic first;
      logic last;
   } beat_tag_t;

endpackage
`default_nettype wire

// File: rtl/sys_mac_pe_mul.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pipe
//  Description : Pipelined full-width multiplier with a valid/tag sideband.
//                The product of an accepted operand pair is available at the
//                output MUL_LAT register stages after it is presented.
//  Ports       : clk, rst      clock, async active-high reset
//                valid_i       operand pair present this cycle
//                a_i, b_i      operands (DATA_W)
//                tag_i         first/last framing of the pair
//                valid_o       product valid at the pipeline output
//                prod_o        2*DATA_W product
//                tag_o         framing carried with the product
//  Revision    : 1.0  initial release
// ============================================================================
module mul_pipe
   import sys_mac_pe_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int SIGNED  = ARITH_SIGNED
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [DATA_W-1:0]     a_i,
   input  logic [DATA_W-1:0]     b_i,
   input  beat_tag_t             tag_i,
   output logic                  valid_o,
   output logic [2*DATA_W-1:0]   prod_o,
   output beat_tag_t             tag_o
);

   localparam int PROD_W = 2 * DATA_W;

   logic [PROD_W-1:0] w_prod;

   generate
      if (SIGNED == ARITH_SIGNED) begin : g_signed
         logic signed [PROD_W-1:0] w_as;
         logic signed [PROD_W-1:0] w_bs;
         assign w_as   = PROD_W'($signed(a_i));
         assign w_bs   = PROD_W'($signed(b_i));
         assign w_prod = w_as * w_bs;
      end else begin : g_unsigned
         assign w_prod = PROD_W'(a_i) * PROD_W'(b_i);
      end
   endgenerate

   logic [PROD_W-1:0]  prod_q [MUL_LAT];
   beat_tag_t          tag_q  [MUL_LAT];
   logic [MUL_LAT-1:0] valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < MUL_LAT; i++) begin
            prod_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         valid_q[0] <= valid_i;
         prod_q[0]  <= w_prod;
         tag_q[0]   <= tag_i;
         for (int i = 1; i < MUL_LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            prod_q[i]  <= prod_q[i-1];
            tag_q[i]   <= tag_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[MUL_LAT-1];
   assign prod_o  = prod_q[MUL_LAT-1];
   assign tag_o   = tag_q[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sys_mac_pe.sv
`default_nettype none
// ============================================================================
//  Module      : sys_mac_pe
//  Description : Systolic-array MAC processing element. Forwards operands to
//                the east/south neighbours, multiplies each accepted beat,
//                accumulates a framed dot product with sticky overflow and
//                presents the result on a valid/ready output.
//  Ports       : clk, rst              clock, async active-high reset
//                in_valid/in_ready     operand beat handshake
//                a_in, b_in            row / column operands
//                first_in, last_in     dot-product framing
//                a_out, b_out          forwarded operands, fwd_valid strobe
//                res_valid/res_ready   result handshake
//                res_data, res_ovf     dot-product sum and overflow flag
//  Revision    : 1.0  initial release
// ============================================================================
module sys_mac_pe
   import sys_mac_pe_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int SIGNED  = ARITH_SIGNED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              first_in,
   input  logic              last_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              fwd_valid,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_ovf
);

   localparam int PROD_W = 2 * DATA_W;

   logic              w_accept;
   logic              w_res_take;
   beat_tag_t         w_tag_in;
   beat_tag_t         w_ptag;
   logic              w_pvalid;
   logic [PROD_W-1:0] w_prod;
   logic [ACC_W-1:0]  w_prod_ext;
   logic [ACC_W-1:0]  w_sum;
   logic              w_sum_ovf;

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic              fin_q;
   logic              in_ready_q;
   logic [DATA_W-1:0] a_out_q, b_out_q;
   logic              fwd_valid_q;
   logic              res_valid_q;
   logic [ACC_W-1:0]  res_data_q;
   logic              res_ovf_q;

   assign w_accept       = in_valid & in_ready_q;
   assign w_res_take     = res_valid_q & res_ready;
   assign w_tag_in.first = first_in;
   assign w_tag_in.last  = last_in;

   mul_pipe #(
      .DATA_W  (DATA_W),
      .MUL_LAT (MUL_LAT),
      .SIGNED  (SIGNED)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .valid_i (w_accept),
      .a_i     (a_in),
      .b_i     (b_in),
      .tag_i   (w_tag_in),
      .valid_o (w_pvalid),
      .prod_o  (w_prod),
      .tag_o   (w_ptag)
   );

   generate
      if (SIGNED == ARITH_SIGNED) begin : g_acc_signed
         assign w_prod_ext = ACC_W'($signed(w_prod));
         assign w_sum      = acc_q + w_prod_ext;
         // Same-sign operands whose sum flips sign have left the range.
         assign w_sum_ovf  = (acc_q[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                             (w_sum[ACC_W-1] != acc_q[ACC_W-1]);
      end else begin : g_acc_unsigned
         logic w_carry;
         assign w_prod_ext       = ACC_W'(w_prod);
         assign {w_carry, w_sum} = {1'b0, acc_q} + {1'b0, w_prod_ext};
         assign w_sum_ovf        = w_carry;
      end
   endgenerate

   // A first-tagged product restarts the sum; anything else continues it.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (w_pvalid) begin
         if (w_ptag.first) begin
            acc_d = w_prod_ext;
            ovf_d = 1'b0;
         end else begin
            acc_d = w_sum;
            ovf_d = ovf_q | w_sum_ovf;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         fin_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         a_out_q     <= '0;
         b_out_q     <= '0;
         fwd_valid_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_ovf_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         // fin_q marks the cycle in which acc/ovf hold a completed sum.
         fin_q       <= w_pvalid & w_ptag.last;
         fwd_valid_q <= w_accept;
         if (w_accept) begin
            a_out_q <= a_in;
            b_out_q <= b_in;
         end
         if (fin_q) begin
            res_valid_q <= 1'b1;
            res_data_q  <= acc_q;
            res_ovf_q   <= ovf_q;
         end else if (w_res_take) begin
            res_valid_q <= 1'b0;
         end
         // Only one dot product may be outstanding: stall input from the
         // last beat until its result has been taken.
         if (w_accept && last_in) begin
            in_ready_q <= 1'b0;
         end else if (w_res_take) begin
            in_ready_q <= 1'b1;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign a_out     = a_out_q;
   assign b_out     = b_out_q;
   assign fwd_valid = fwd_valid_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_ovf   = res_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_mac_pe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_mac_pe
//  Description : Self-checking bench for sys_mac_pe. A signed (ACC_W=32) and
//                an unsigned (ACC_W=16) instance share one stimulus stream;
//                a behavioural model queues expected results per last beat.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sys_mac_pe;

   localparam int DW   = 8;
   localparam int LAT  = 3;
   localparam int AW_S = 32;
   localparam int AW_U = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          first_in = 1'b0;
   logic          last_in = 1'b0;
   logic          res_ready = 1'b0;
   logic [DW-1:0] a_in = '0;
   logic [DW-1:0] b_in = '0;

   logic            s_in_ready, s_fwd_valid, s_res_valid, s_res_ovf;
   logic [DW-1:0]   s_a_out, s_b_out;
   logic [AW_S-1:0] s_res_data;
   logic            u_in_ready, u_fwd_valid, u_res_valid, u_res_ovf;
   logic [DW-1:0]   u_a_out, u_b_out;
   logic [AW_U-1:0] u_res_data;

   sys_mac_pe #(.DATA_W(DW), .ACC_W(AW_S), .MUL_LAT(LAT), .SIGNED(1)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .a_in(a_in), .b_in(b_in), .first_in(first_in), .last_in(last_in),
      .a_out(s_a_out), .b_out(s_b_out), .fwd_valid(s_fwd_valid),
      .res_valid(s_res_valid), .res_ready(res_ready),
      .res_data(s_res_data), .res_ovf(s_res_ovf)
   );

   sys_mac_pe #(.DATA_W(DW), .ACC_W(AW_U), .MUL_LAT(LAT), .SIGNED(0)) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
      .a_in(a_in), .b_in(b_in), .first_in(first_in), .last_in(last_in),
      .a_out(u_a_out), .b_out(u_b_out), .fwd_valid(u_fwd_valid),
      .res_valid(u_res_valid), .res_ready(res_ready),
      .res_data(u_res_data), .res_ovf(u_res_ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW_S-1:0] d_s;
      logic            o_s;
      logic [AW_U-1:0] d_u;
      logic            o_u;
   } exp_t;

   exp_t   exp_q[$];
   exp_t   e;
   longint m_acc_s = 0;
   longint m_acc_u = 0;
   bit     m_ovf_s = 0;
   bit     m_ovf_u = 0;
   int     last_acc_cyc = 0;
   int     n_pass = 0;
   int     n_total = 0;

   // Reference model: exact integer arithmetic, then wrap to the accumulator.
   task automatic model_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input bit f, input bit l);
      longint ps, pu, t;
      int     t32;
      ps = longint'($signed(a)) * longint'($signed(b));
      pu = longint'(a) * longint'(b);
      if (f) begin
         m_acc_s = ps; m_ovf_s = 0;
         m_acc_u = pu; m_ovf_u = 0;
      end else begin
         t = m_acc_s + ps;
         if (t > 64'sd2147483647 || t < -64'sd2147483648) m_ovf_s = 1;
         t32 = t[31:0];
         m_acc_s = t32;
         t = m_acc_u + pu;
         if (t > 65535) m_ovf_u = 1;
         m_acc_u = t & 65535;
      end
      if (l) exp_q.push_back('{d_s: m_acc_s[AW_S-1:0], o_s: m_ovf_s,
                               d_u: m_acc_u[AW_U-1:0], o_u: m_ovf_u});
   endtask

   task automatic model_reset();
      m_acc_s = 0; m_acc_u = 0; m_ovf_s = 0; m_ovf_u = 0;
      exp_q.delete();
   endtask

   // Offer a beat (called #1 after an edge); returns #1 after the accept edge.
   task automatic drive_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input bit f, input bit l);
      int w;
      w = 0;
      in_valid = 1'b1; a_in = a; b_in = b; first_in = f; last_in = l;
      while (!s_in_ready && w < 30) begin
         @(posedge clk); #1; w++;
      end
      if (!s_in_ready) begin
         n_total++;
         $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", s_in_ready, w);
      end else begin
         @(posedge clk);
         model_beat(a, b, f, l);
         #1;
         last_acc_cyc = cyc;
      end
   endtask

   task automatic idle();
      in_valid = 1'b0; first_in = 1'b0; last_in = 1'b0;
   endtask

   task automatic wait_res(output bit ok, output int lat);
      int w;
      w = 0;
      while (!s_res_valid && w < 40) begin
         @(posedge clk); #1; w++;
      end
      ok  = s_res_valid;
      lat = cyc - last_acc_cyc;
      if (!ok) begin
         n_total++;
         $display("FAIL res_timeout: res_valid=%0b after %0d cycles, required 1", s_res_valid, w);
      end
   endtask

   task automatic take_res();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle();
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({s_res_valid, s_res_data, s_res_ovf, s_a_out, s_b_out, s_fwd_valid, s_in_ready} !== {1'b0, 32'h0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b1})
         $display("FAIL reset_signed: got rv=%0b rd=%h ro=%0b a=%h b=%h fv=%0b ir=%0b, required all zero with in_ready=1",
                  s_res_valid, s_res_data, s_res_ovf, s_a_out, s_b_out, s_fwd_valid, s_in_ready);
      else n_pass++;
      n_total++;
      if ({u_res_valid, u_res_data, u_res_ovf, u_a_out, u_b_out, u_fwd_valid, u_in_ready} !== {1'b0, 16'h0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b1})
         $display("FAIL reset_unsigned: got rv=%0b rd=%h ro=%0b a=%h b=%h fv=%0b ir=%0b, required all zero with in_ready=1",
                  u_res_valid, u_res_data, u_res_ovf, u_a_out, u_b_out, u_fwd_valid, u_in_ready);
      else n_pass++;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_signed_dot();
      bit ok; int lat;
      drive_beat(8'd3, 8'd4, 1, 0);
      drive_beat(8'hFE, 8'd5, 0, 0);
      drive_beat(8'd7, 8'hFF, 0, 1);
      idle();
      wait_res(ok, lat);
      if (ok) begin
         e = exp_q.pop_front();
         n_total++;
         if (lat !== LAT + 1) $display("FAIL sdot_latency: got %0d cycles, required %0d", lat, LAT + 1);
         else n_pass++;
         n_total++;
         if ({s_res_data, s_res_ovf} !== {32'hFFFF_FFFB, 1'b0})
            $display("FAIL sdot_value: got %h/%0b, required fffffffb/0", s_res_data, s_res_ovf);
         else n_pass++;
         n_total++;
         if ({s_res_data, s_res_ovf, u_res_data, u_res_ovf} !== {e.d_s, e.o_s, e.d_u, e.o_u})
            $display("FAIL sdot_scoreboard: got %h/%0b %h/%0b, required %h/%0b %h/%0b",
                     s_res_data, s_res_ovf, u_res_data, u_res_ovf, e.d_s, e.o_s, e.d_u, e.o_u);
         else n_pass++;
         take_res();
      end
   endtask

   task automatic test_unsigned_ovf();
      bit ok; int lat;
      drive_beat(8'hFF, 8'hFF, 1, 0);
      drive_beat(8'hFF, 8'hFF, 0, 1);
      idle();
      wait_res(ok, lat);
      if (ok) begin
         e = exp_q.pop_front();
         n_total++;
         if ({u_res_data, u_res_ovf} !== {16'hFC02, 1'b1})
            $display("FAIL uovf_value: got %h/%0b, required fc02/1", u_res_data, u_res_ovf);
         else n_pass++;
         n_total++;
         if ({s_res_data, s_res_ovf, u_res_data, u_res_ovf} !== {e.d_s, e.o_s, e.d_u, e.o_u})
            $display("FAIL uovf_scoreboard: got %h/%0b %h/%0b, required %h/%0b %h/%0b",
                     s_res_data, s_res_ovf, u_res_data, u_res_ovf, e.d_s, e.o_s, e.d_u, e.o_u);
         else n_pass++;
         take_res();
      end
      drive_beat(8'd1, 8'd1, 1, 1);
      idle();
      wait_res(ok, lat);
      if (ok) begin
         e = exp_q.pop_front();
         n_total++;
         if ({u_res_data, u_res_ovf, s_res_data, s_res_ovf} !== {16'h0001, 1'b0, 32'h1, 1'b0})
            $display("FAIL uovf_clear: got %h/%0b %h/%0b, required 0001/0 00000001/0",
                     u_res_data, u_res_ovf, s_res_data, s_res_ovf);
         else n_pass++;
         take_res();
      end
   endtask

   task automatic test_backpressure();
      bit ok; int lat; bit bad;
      drive_beat(8'd5, 8'd6, 1, 1);
      idle();
      wait_res(ok, lat);
      if (ok) begin
         e = exp_q.pop_front();
         n_total++;
         if ({s_res_data, s_res_ovf, u_res_data, u_res_ovf} !== {e.d_s, e.o_s, e.d_u, e.o_u})
            $display("FAIL bp_scoreboard: got %h/%0b %h/%0b, required %h/%0b %h/%0b",
                     s_res_data, s_res_ovf, u_res_data, u_res_ovf, e.d_s, e.o_s, e.d_u, e.o_u);
         else n_pass++;
         // Offer a restarting beat while stalled; it must be ignored.
         in_valid = 1'b1; a_in = 8'd9; b_in = 8'd9; first_in = 1'b1; last_in = 1'b0;
         bad = 0;
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (s_res_valid !== 1'b1 || s_res_data !== e.d_s || s_in_ready !== 1'b0 ||
                s_fwd_valid !== 1'b0 || u_res_data !== e.d_u || u_in_ready !== 1'b0) bad = 1;
         end
         n_total++;
         if (bad) $display("FAIL bp_hold: rv=%0b rd=%h ir=%0b fv=%0b, required 1/%h/0/0 for 10 cycles",
                           s_res_valid, s_res_data, s_in_ready, s_fwd_valid, e.d_s);
         else n_pass++;
         idle();
         take_res();
         n_total++;
         if ({s_res_valid, s_in_ready, u_res_valid, u_in_ready} !== 4'b0101)
            $display("FAIL bp_release: got rv=%0b ir=%0b, required rv=0 ir=1", s_res_valid, s_in_ready);
         else n_pass++;
      end
      // Continuation without first adds onto the held sum (30 + 6).
      drive_beat(8'd2, 8'd3, 0, 1);
      idle();
      wait_res(ok, lat);
      if (ok) begin
         e = exp_q.pop_front();
         n_total++;
         if ({s_res_data, u_res_data} !== {32'd36, 16'd36} ||
             {s_res_data, s_res_ovf, u_res_data, u_res_ovf} !== {e.d_s, e.o_s, e.d_u, e.o_u})
            $display("FAIL continuation: got %0d/%0d, required 36/36 (model %0d/%0d)",
                     s_res_data, u_res_data, e.d_s, e.d_u);
         else n_pass++;
         take_res();
      end
   endtask

   task automatic test_back_to_back();
      bit ok; int lat;
      logic [DW-1:0] av[4];
      bit fwd_bad;
      av[0] = 8'd1; av[1] = 8'd2; av[2] = 8'd3; av[3] = 8'd4;
      res_ready = 1'b1;
      fwd_bad = 0;
      for (int i = 0; i < 4; i++) begin
         drive_beat(av[i], av[i], i == 0, i == 3);
         if (s_a_out !== av[i] || s_b_out !== av[i] || s_fwd_valid !== 1'b1 ||
             u_a_out !== av[i] || u_fwd_valid !== 1'b1) begin
            fwd_bad = 1;
            $display("FAIL b2b_forward: beat %0d got a=%h b=%h fv=%0b, required a=b=%h fv=1",
                     i, s_a_out, s_b_out, s_fwd_valid, av[i]);
         end
      end
      n_total++;
      if (!fwd_bad) n_pass++;
      idle();
      @(posedge clk); #1;
      n_total++;
      if ({s_fwd_valid, s_a_out, s_b_out} !== {1'b0, 8'd4, 8'd4})
         $display("FAIL b2b_fwd_hold: got fv=%0b a=%h b=%h, required 0/04/04", s_fwd_valid, s_a_out, s_b_out);
      else n_pass++;
      wait_res(ok, lat);
      if (ok) begin
         e = exp_q.pop_front();
         n_total++;
         if ({s_res_data, u_res_data} !== {32'd30, 16'd30} ||
             {s_res_data, s_res_ovf, u_res_data, u_res_ovf} !== {e.d_s, e.o_s, e.d_u, e.o_u})
            $display("FAIL b2b_sum: got %0d/%0d, required 30/30 (model %0d/%0d)",
                     s_res_data, u_res_data, e.d_s, e.d_u);
         else n_pass++;
         @(posedge clk); #1;
         n_total++;
         if ({s_res_valid, s_in_ready} !== 2'b01)
            $display("FAIL b2b_consume: got rv=%0b ir=%0b, required rv=0 ir=1", s_res_valid, s_in_ready);
         else n_pass++;
      end
      res_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok; int lat; int c0;
      drive_beat(8'd1, 8'd2, 1, 0);
      drive_beat(8'd3, 8'd4, 0, 0);
      in_valid = 1'b1; a_in = 8'd5; b_in = 8'd6; first_in = 1'b0; last_in = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      n_total++;
      if ({s_res_valid, s_res_data, s_res_ovf, s_a_out, s_b_out, s_fwd_valid, s_in_ready} !== {1'b0, 32'h0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b1})
         $display("FAIL midrst_outputs: got rv=%0b rd=%h a=%h b=%h fv=%0b ir=%0b, required zero with in_ready=1",
                  s_res_valid, s_res_data, s_a_out, s_b_out, s_fwd_valid, s_in_ready);
      else n_pass++;
      model_reset();
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      c0 = cyc;
      drive_beat(8'd6, 8'd7, 1, 1);
      n_total++;
      if (last_acc_cyc !== c0 + 1)
         $display("FAIL midrst_first_accept: accepted %0d cycles after release, required 1", last_acc_cyc - c0);
      else n_pass++;
      idle();
      wait_res(ok, lat);
      if (ok) begin
         e = exp_q.pop_front();
         n_total++;
         if ({s_res_data, s_res_ovf, u_res_data} !== {32'd42, 1'b0, 16'd42} ||
             {s_res_data, s_res_ovf, u_res_data, u_res_ovf} !== {e.d_s, e.o_s, e.d_u, e.o_u})
            $display("FAIL midrst_result: got %0d/%0b %0d, required 42/0 42", s_res_data, s_res_ovf, u_res_data);
         else n_pass++;
         take_res();
      end
      repeat (6) @(posedge clk);
      #1;
      n_total++;
      if ({s_res_valid, u_res_valid} !== 2'b00 || exp_q.size() != 0)
         $display("FAIL no_ghost_result: got rv=%0b/%0b queue=%0d, required 0/0 and 0",
                  s_res_valid, u_res_valid, exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_signed_dot();
      test_unsigned_ovf();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/sys_mac_pe.md
SYS_MAC_PE -- requirements
Module: sys_mac_pe

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand width.
REQ-002 SHALL have parameter ACC_W, default 72: accumulator width; legal range is 2*DATA_W to 2*DATA_W+16.
REQ-003 SHALL have parameter MUL_LAT, default 3: multiplier pipeline depth; legal range is 1 to 8.
REQ-004 SHALL have parameter SIGNED, default 1: 1 selects two's-complement arithmetic, 0 selects unsigned.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  operand beat offered.
REQ-008 SHALL have port in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port a_in  input  DATA_W  row operand.
REQ-010 SHALL have port b_in  input  DATA_W  column operand.
REQ-011 SHALL have port first_in  input  1  beat starts a new dot product.
REQ-012 SHALL have port last_in  input  1  beat ends the dot product.
REQ-013 SHALL have port a_out  output  DATA_W  a_in forwarded to the east neighbour.
REQ-014 SHALL have port b_out  output  DATA_W  b_in forwarded to the south neighbour.
REQ-015 SHALL have port fwd_valid  output  1  a_out/b_out hold an accepted beat.
REQ-016 SHALL have port res_valid  output  1  result available.
REQ-017 SHALL have port res_ready  input  1  consumer takes the result.
REQ-018 SHALL have port res_data  output  ACC_W  dot-product sum.
REQ-019 SHALL have port res_ovf  output  1  sum overflowed ACC_W.

Function
REQ-020 Operand forwarding: on every accepted beat, a_out/b_out SHALL load a_in/b_in; fwd_valid SHALL be high the next cycle only, low otherwise; a_out/b_out hold their value when no beat is accepted.
REQ-021 Multiply: each accepted beat SHALL form a full 2*DATA_W product, sign- or zero-extended to ACC_W per SIGNED, emerging exactly MUL_LAT cycles after acceptance, with first/last tags carried alongside.
REQ-022 Accumulate: on an emerging product, acc SHALL load product if tagged first, else acc+product; one product per cycle, no bubbles required.
REQ-023 Overflow: acc+product exceeding the ACC_W range (signed or unsigned per SIGNED) SHALL set a sticky ovf bit; the sum wraps modulo 2^ACC_W; a first-tagged product clears ovf.
REQ-024 Result: on an emerging last-tagged product, res_data/res_ovf SHALL load the final acc/ovf and res_valid SHALL rise the next cycle; latency from last-beat acceptance to res_valid is MUL_LAT+1 cycles.
REQ-025 A beat tagged both first and last SHALL yield res_data = its product.
REQ-026 Product without a prior first SHALL accumulate onto the existing acc (continuation allowed).
REQ-027 res_valid, res_data and res_ovf SHALL hold stable until res_ready is sampled high; res_valid clears that same edge.
REQ-028 in_ready SHALL drop the cycle after a last beat is accepted and SHALL stay low until the cycle after that result's res_valid&res_ready handshake; in_ready is otherwise high.
REQ-029 in_valid or other inputs changing while in_ready is low SHALL have no effect.
REQ-030 res_ready asserted while res_valid is low SHALL be ignored.

Reset
REQ-031 rst SHALL asynchronously clear acc, ovf, all pipeline stages and tags, a_out, b_out, fwd_valid, res_valid, res_data and res_ovf, and SHALL set in_ready to 1.
REQ-032 rst asserted mid-dot-product SHALL discard in-flight products and produce no result.
REQ-033 After rst deasserts, the first beat SHALL be accepted on the next edge.

Structure
REQ-034 Shared package SHALL hold the default widths, the MUL_LAT limits and the SIGNED encoding constants.
REQ-035 Sub-module mul_pipe (DATA_W, MUL_LAT, SIGNED) SHALL implement the pipelined multiplier with a valid/tag sideband; sys_mac_pe holds the forwarding, accumulator, result and handshake logic.

Verification
REQ-036 DATA_W=8, SIGNED=1: beats (3,4,first), (-2,5), (7,-1,last) -> res_data=-5, res_ovf=0, res_valid exactly MUL_LAT+1 cycles after the last beat.
REQ-037 SIGNED=0, DATA_W=8, ACC_W=16: (255,255,first), (255,255,last) -> res_data=0xFC02, res_ovf=1; next product (1,1,first,last) -> res_data=1, res_ovf=0.
REQ-038 res_ready held low 10 cycles after res_valid -> res_data stable, in_ready low throughout, new beats are not accepted; res_ready high -> in_ready returns the following cycle.
REQ-039 Back-to-back beats (1,1),(2,2),(3,3),(4,4), last on 4 -> res_data=30; a_out/b_out show each operand one cycle after acceptance with fwd_valid high.
REQ-040 rst pulsed two cycles into a 4-beat product -> all outputs zero and in_ready=1; a fresh (6,7,first,last) beat -> res_data=42.
